// File: rtl/m_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : m_unit_arbiter
// Brief    : Round-robin arbiter that shares one multiply/divide (M) unit
//            among NREQ requesters. Captures the winner's operands, issues a
//            start pulse, waits for the unit to finish and returns the result
//            to the owner on a shared bus. The owner may cancel its operation
//            while it is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module m_unit_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*XLEN-1:0] i_rs1,
  input  logic [NREQ*XLEN-1:0] i_rs2,
  input  logic [NREQ*3-1:0]    i_f3,
  input  logic [NREQ-1:0]      i_kill,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_done,
  output logic [XLEN-1:0]      o_res,
  output logic                 o_busy,
  output logic                 o_m_start,
  output logic [2:0]           o_m_f3,
  output logic [XLEN-1:0]      o_m_rs1,
  output logic [XLEN-1:0]      o_m_rs2,
  input  logic                 i_m_done,
  input  logic [XLEN-1:0]      i_m_res
);

  localparam int c_idx_w = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q,   state_d;
  logic [c_idx_w-1:0]   owner_q,   owner_d;
  logic [c_idx_w-1:0]   last_q,    last_d;
  logic [XLEN-1:0]      rs1_q,     rs1_d;
  logic [XLEN-1:0]      rs2_q,     rs2_d;
  logic [2:0]           f3_q,      f3_d;
  logic [XLEN-1:0]      res_q,     res_d;
  logic                 kill_q,    kill_d;
  logic [NREQ-1:0]      gnt_q,     gnt_d;
  logic [NREQ-1:0]      done_q,    done_d;
  logic                 m_start_q, m_start_d;
  logic                 busy_q,    busy_d;

  // Per-requester views of the packed operand buses
  logic [XLEN-1:0]      w_rs1 [NREQ];
  logic [XLEN-1:0]      w_rs2 [NREQ];
  logic [2:0]           w_f3  [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign w_rs1[k] = i_rs1[k*XLEN +: XLEN];
    assign w_rs2[k] = i_rs2[k*XLEN +: XLEN];
    assign w_f3[k]  = i_f3[k*3 +: 3];
  end

  logic [c_idx_w-1:0]   w_win;
  logic                 w_any;

  // Round-robin search starting just after the previous owner, wrapping at NREQ
  always_comb begin : p_rr
    logic [c_idx_w:0] cand;
    w_win = last_q;
    w_any = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_q} + (c_idx_w+1)'(i);
      if (cand >= (c_idx_w+1)'(NREQ)) begin
        cand = cand - (c_idx_w+1)'(NREQ);
      end
      if (!w_any && i_req[cand[c_idx_w-1:0]]) begin
        w_any = 1'b1;
        w_win = cand[c_idx_w-1:0];
      end
    end
  end

  // Next-state and next-output computation for the arbitration sequence
  always_comb begin : p_next
    logic kill_now;
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    f3_d      = f3_q;
    res_d     = res_q;
    kill_d    = kill_q;
    gnt_d     = '0;
    done_d    = '0;
    m_start_d = 1'b0;
    kill_now  = kill_q | i_kill[owner_q];

    case (state_q)
      S_IDLE: begin
        if (w_any) begin
          owner_d        = w_win;
          last_d         = w_win;
          rs1_d          = w_rs1[w_win];
          rs2_d          = w_rs2[w_win];
          f3_d           = w_f3[w_win];
          kill_d         = 1'b0;
          gnt_d[w_win]   = 1'b1;
          m_start_d      = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        kill_d  = kill_now;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A kill arriving on the completion edge still suppresses the response
        kill_d = kill_now;
        if (i_m_done) begin
          if (kill_now) begin
            state_d = S_IDLE;
          end else begin
            res_d           = i_m_res;
            done_d[owner_q] = 1'b1;
            state_d         = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output update; reset abandons any operation
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      last_q    <= c_idx_w'(NREQ-1);
      rs1_q     <= '0;
      rs2_q     <= '0;
      f3_q      <= '0;
      res_q     <= '0;
      kill_q    <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      m_start_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      f3_q      <= f3_d;
      res_q     <= res_d;
      kill_q    <= kill_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      m_start_q <= m_start_d;
      busy_q    <= busy_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_done    = done_q;
  assign o_res     = res_q;
  assign o_busy    = busy_q;
  assign o_m_start = m_start_q;
  assign o_m_f3    = f3_q;
  assign o_m_rs1   = rs1_q;
  assign o_m_rs2   = rs2_q;

endmodule
`default_nettype wire

// File: tb/tb_m_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_unit_arbiter
// Brief    : Self-checking bench for m_unit_arbiter. Requesters, the shared
//            M unit and a transaction-level arbitration model live here;
//            directed scenarios are followed by a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_unit_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 3;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req, kill;
  logic [NREQ*XLEN-1:0] rs1, rs2;
  logic [NREQ*3-1:0]    f3;
  logic                 m_done;
  logic [XLEN-1:0]      m_res;
  logic [NREQ-1:0]      gnt, done_o;
  logic [XLEN-1:0]      res, m_rs1, m_rs2;
  logic                 busy, m_start;
  logic [2:0]           m_f3;

  m_unit_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_rs1(rs1), .i_rs2(rs2),
    .i_f3(f3), .i_kill(kill), .o_gnt(gnt), .o_done(done_o), .o_res(res),
    .o_busy(busy), .o_m_start(m_start), .o_m_f3(m_f3), .o_m_rs1(m_rs1),
    .o_m_rs2(m_rs2), .i_m_done(m_done), .i_m_res(m_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Requesters
  logic [XLEN-1:0] q_rs1 [NREQ];
  logic [XLEN-1:0] q_rs2 [NREQ];
  logic [2:0]      q_f3  [NREQ];
  logic [NREQ-1:0] want, hold_mask;
  int  auto_pct, kill_mode, fixed_delay;
  bit  spur;

  // Transaction-level arbitration model
  bit              op_active, killed;
  int              owner, grant_cyc, last, cyc;
  logic [XLEN-1:0] op_res, op_rs1, op_rs2, exp_res;
  logic [2:0]      op_f3;
  logic [NREQ-1:0] exp_gnt, exp_done;

  // Shared M unit model
  bit              mu_active;
  int              mu_cnt;
  logic [XLEN-1:0] mu_res, s_rs1, s_rs2;
  logic [2:0]      s_f3;
  logic            s_start;

  // Observation logs
  int              gnt_log[$];
  int              gnt_cyc_log[$];
  int              gnt_cnt, done_cnt, last_done_cyc;
  logic [XLEN-1:0] last_done_res;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension result for the given funct3
  function automatic logic [31:0] mref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0]        p;
    logic signed [31:0] sa32, sb32;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    sa32 = a;
    sb32 = b;
    case (f)
      3'd0: begin p = sa * sb;             return p[31:0];  end
      3'd1: begin p = sa * sb;             return p[63:32]; end
      3'd2: begin p = sa * ub;             return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return a;
        return sa32 / sb32;
      end
      3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'd0;
        return sa32 % sb32;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int rr_pick(input int lst, input logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++) begin
      if (r[(lst + i) % NREQ]) return (lst + i) % NREQ;
    end
    return lst;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    op_active = 1'b0; killed = 1'b0; owner = 0; grant_cyc = -100;
    last = NREQ - 1; cyc = 0;
    exp_gnt = '0; exp_done = '0; exp_res = '0;
    op_res = '0; op_rs1 = '0; op_rs2 = '0; op_f3 = '0;
    mu_active = 1'b0; mu_cnt = 0; mu_res = '0;
    s_start = 1'b0; s_f3 = '0; s_rs1 = '0; s_rs2 = '0;
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NREQ; k++) begin
      rs1[k*XLEN +: XLEN] = q_rs1[k];
      rs2[k*XLEN +: XLEN] = q_rs2[k];
      f3[k*3 +: 3]        = q_f3[k];
    end
    req = want;
    if (mu_active) begin
      m_done = (mu_cnt == 0);
      m_res  = (mu_cnt == 0) ? mu_res : $urandom;
    end else begin
      m_done = spur ? 1'b1 : 1'($urandom_range(0, 1));
      m_res  = $urandom;
    end
    kill = '0;
    case (kill_mode)
      0: for (int k = 0; k < NREQ; k++) kill[k] = ($urandom_range(0, 9) == 0);
      2: if (op_active && mu_active && mu_cnt == 0) kill[owner] = 1'b1;
      3: if (op_active) begin kill = '1; kill[owner] = 1'b0; end
      4: if (op_active && cyc == grant_cyc + 1) kill[owner] = 1'b1;
      default: kill = '0;
    endcase
  endtask

  // One clock: advance the models on the edge, compare, then drive the next cycle
  task automatic step();
    logic [NREQ-1:0] ng, nd;
    int w;
    @(posedge clk);
    cyc++;
    ng = '0;
    nd = '0;
    if (op_active) begin
      if (kill[owner]) killed = 1'b1;
      if ((cyc - 1) > grant_cyc && m_done) begin
        op_active = 1'b0;
        if (!killed) begin
          nd[owner] = 1'b1;
          exp_res   = op_res;
        end
      end
    end else if (exp_done == '0 && req != '0) begin
      w         = rr_pick(last, req);
      owner     = w;
      last      = w;
      killed    = 1'b0;
      grant_cyc = cyc;
      op_active = 1'b1;
      op_rs1    = rs1[w*XLEN +: XLEN];
      op_rs2    = rs2[w*XLEN +: XLEN];
      op_f3     = f3[w*3 +: 3];
      op_res    = mref(op_f3, op_rs1, op_rs2);
      ng[w]     = 1'b1;
    end
    exp_gnt  = ng;
    exp_done = nd;
    if (s_start) begin
      mu_active = 1'b1;
      mu_cnt    = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
      mu_res    = mref(s_f3, s_rs1, s_rs2);
    end else if (mu_active) begin
      if (m_done) mu_active = 1'b0;
      else if (mu_cnt > 0) mu_cnt--;
    end
    #1;
    check_eq("gnt", gnt, exp_gnt);
    check_eq("done", done_o, exp_done);
    check_eq("res", res, exp_res);
    check_eq("busy", busy, (op_active || nd != '0));
    check_eq("m_start", m_start, (ng != '0));
    if (op_active) begin
      check_eq("m_rs1", m_rs1, op_rs1);
      check_eq("m_rs2", m_rs2, op_rs2);
      check_eq("m_f3", m_f3, op_f3);
    end
    s_start = m_start; s_f3 = m_f3; s_rs1 = m_rs1; s_rs2 = m_rs2;
    if (gnt != '0) begin
      gnt_cnt++;
      for (int k = 0; k < NREQ; k++) begin
        if (gnt[k]) begin gnt_log.push_back(k); gnt_cyc_log.push_back(cyc); end
      end
    end
    if (done_o != '0) begin
      done_cnt++;
      last_done_cyc = cyc;
      last_done_res = res;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k] && !hold_mask[k]) want[k] = 1'b0;
      if (!want[k] && auto_pct > 0 && $urandom_range(0, 99) < auto_pct) begin
        want[k]  = 1'b1;
        q_rs1[k] = rand_opnd();
        q_rs2[k] = rand_opnd();
        q_f3[k]  = 3'($urandom_range(0, 7));
      end
    end
    drive_inputs();
  endtask

  task automatic run_until_quiet(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (!op_active && exp_done == '0 && want == '0) break;
    end
    check_eq("drain", (op_active || want != '0), 1'b0);
  endtask

  task automatic clear_logs();
    gnt_log.delete(); gnt_cyc_log.delete();
    gnt_cnt = 0; done_cnt = 0; last_done_cyc = -1; last_done_res = '0;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    q_rs1[k] = a; q_rs2[k] = b; q_f3[k] = f; want[k] = 1'b1;
  endtask

  logic [XLEN-1:0] s3_res;

  initial begin
    rst_n = 1'b0;
    want = '0; hold_mask = '0; auto_pct = 0; kill_mode = 1; fixed_delay = 2; spur = 1'b0;
    for (int k = 0; k < NREQ; k++) begin q_rs1[k] = '0; q_rs2[k] = '0; q_f3[k] = '0; end
    model_reset();
    clear_logs();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_m_start", m_start, 0);
    check_eq("rst_res", res, 0);
    check_eq("rst_m_rs1", m_rs1, 0);
    check_eq("rst_m_rs2", m_rs2, 0);
    check_eq("rst_m_f3", m_f3, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: 7 * 6, unit done three cycles after start
    clear_logs();
    set_req(0, 32'd7, 32'd6, 3'd0);
    drive_inputs();
    run_until_quiet(40);
    check_eq("s1_ngnt", gnt_log.size(), 1);
    if (gnt_log.size() >= 1) begin
      check_eq("s1_gnt_cycle", gnt_cyc_log[0], 1);
      check_eq("s1_gnt_owner", gnt_log[0], 0);
      check_eq("s1_latency", last_done_cyc - gnt_cyc_log[0], 4);
    end
    check_eq("s1_result", last_done_res, 42);
    step();
    check_eq("s1_busy_after", busy, 0);

    // Two requesters held continuously from reset release
    do_reset();
    clear_logs();
    hold_mask = 3'b011;
    fixed_delay = -1;
    set_req(0, rand_opnd(), rand_opnd(), 3'd1);
    set_req(1, rand_opnd(), rand_opnd(), 3'd4);
    drive_inputs();
    for (int i = 0; i < 80 && gnt_log.size() < 4; i++) step();
    hold_mask = '0;
    want = '0;
    run_until_quiet(40);
    check_eq("s2_count", (gnt_log.size() >= 4), 1);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
      check_eq("s2_order", gnt_log[i], i % 2);
      if (i > 0) check_eq("s2_spacing", (gnt_cyc_log[i] - gnt_cyc_log[i-1]) >= 4, 1);
    end

    // Owner kills its DIVU in the first WAIT cycle
    clear_logs();
    s3_res = exp_res;
    kill_mode = 4; fixed_delay = 3;
    set_req(1, 32'd100, 32'd7, 3'd5);
    drive_inputs();
    run_until_quiet(40);
    check_eq("s3_gnt", gnt_cnt, 1);
    check_eq("s3_nodone", done_cnt, 0);
    check_eq("s3_res_hold", res, s3_res);
    check_eq("s3_idle", busy, 0);
    clear_logs();
    kill_mode = 1;
    set_req(0, rand_opnd(), rand_opnd(), 3'($urandom_range(0, 7)));
    drive_inputs();
    run_until_quiet(40);
    check_eq("s3_next_gnt", gnt_cnt, 1);
    check_eq("s3_next_done", done_cnt, 1);

    // Kill on the completion edge, then a kill from a non-owner
    clear_logs();
    kill_mode = 2; fixed_delay = 1;
    set_req(0, 32'd5, 32'd9, 3'd0);
    drive_inputs();
    run_until_quiet(40);
    check_eq("s4_coinc_nodone", done_cnt, 0);
    clear_logs();
    kill_mode = 3;
    set_req(1, 32'd81, 32'd9, 3'd5);
    drive_inputs();
    run_until_quiet(40);
    check_eq("s4_nonowner_done", done_cnt, 1);
    check_eq("s4_nonowner_res", last_done_res, 9);

    // Asynchronous reset in the middle of WAIT
    kill_mode = 1; fixed_delay = 4;
    set_req(0, 32'd3, 32'd3, 3'd0);
    drive_inputs();
    for (int i = 0; i < 20 && !(op_active && cyc >= grant_cyc + 2); i++) step();
    check_eq("s5_in_wait", op_active, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("s5_gnt", gnt, 0);
    check_eq("s5_done", done_o, 0);
    check_eq("s5_busy", busy, 0);
    check_eq("s5_m_start", m_start, 0);
    check_eq("s5_res", res, 0);
    check_eq("s5_m_rs1", m_rs1, 0);
    check_eq("s5_m_f3", m_f3, 0);
    repeat (2) @(posedge clk);
    model_reset();
    want = '0; spur = 1'b1;
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (4) step();
    check_eq("s5_stale_nodone", done_cnt, 0);
    spur = 1'b0; fixed_delay = 2;
    set_req(0, 32'd9, 32'd5, 3'd7);
    drive_inputs();
    run_until_quiet(40);
    check_eq("s5_fresh_done", done_cnt, 1);
    check_eq("s5_fresh_res", last_done_res, 4);

    // Spurious completion held high while idle
    clear_logs();
    spur = 1'b1;
    drive_inputs();
    repeat (10) step();
    check_eq("s6_no_gnt", gnt_cnt, 0);
    check_eq("s6_no_done", done_cnt, 0);
    spur = 1'b0;

    // Randomized traffic with random kills and unit latencies
    auto_pct = 25; kill_mode = 0; fixed_delay = -1;
    repeat (3000) step();
    auto_pct = 0; kill_mode = 1;
    run_until_quiet(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_unit_arbiter.md
M_UNIT_ARBITER -- requirements
Module: m_unit_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width.
REQ-002 SHALL have parameter NREQ, default 2, legal range 2..8: number of requesters.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_req, input, NREQ: per-requester request level.
REQ-006 SHALL have port i_rs1, input, NREQ*XLEN: operand 1, requester k at slice [k*XLEN +: XLEN].
REQ-007 SHALL have port i_rs2, input, NREQ*XLEN: operand 2, same slicing.
REQ-008 SHALL have port i_f3, input, NREQ*3: funct3 (MUL..REMU), requester k at [k*3 +: 3].
REQ-009 SHALL have port i_kill, input, NREQ: cancel the in-flight operation owned by requester k.
REQ-010 SHALL have port o_gnt, output, NREQ: one-cycle pulse, request accepted, operands captured.
REQ-011 SHALL have port o_done, output, NREQ: one-cycle pulse, result valid on o_res.
REQ-012 SHALL have port o_res, output, XLEN: shared result bus.
REQ-013 SHALL have port o_busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port o_m_start, output, 1: start pulse to the shared M unit.
REQ-015 SHALL have ports o_m_f3 (3), o_m_rs1 (XLEN), o_m_rs2 (XLEN), outputs: captured operation to the M unit.
REQ-016 SHALL have ports i_m_done (1) and i_m_res (XLEN), inputs: M unit completion level and result.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with state, owner, operand, result, kill-flag and pointer held in registers.
REQ-018 IDLE: when any i_req bit is high at the clock edge, SHALL select the owner by round-robin, capture that requester's i_rs1/i_rs2/i_f3, and move to ISSUE; with no request, SHALL remain in IDLE.
REQ-019 Round-robin: pointer last (register), search order last+1, last+2, ... modulo NREQ; last SHALL be updated to the owner on the IDLE->ISSUE transition.
REQ-020 ISSUE (exactly 1 cycle): o_gnt[owner]=1 and o_m_start=1; SHALL move to WAIT.
REQ-021 o_m_f3/o_m_rs1/o_m_rs2 SHALL drive the captured values from ISSUE through the end of WAIT and hold them stable; after WAIT they are don't-care.
REQ-022 WAIT: i_m_done SHALL be sampled only in this state; the M unit holds done until its next start. On i_m_done=1 the block SHALL latch i_m_res and go to RESP, or go directly to IDLE if the kill flag is set.
REQ-023 RESP (exactly 1 cycle): o_done[owner]=1 and o_res=latched result; SHALL move to IDLE.
REQ-024 Latency: request sampled at edge E0 gives o_gnt/o_m_start in cycle E0..E1; the first WAIT edge with i_m_done high (En) gives o_done in cycle En..En+1.
REQ-025 Minimum spacing between successive grants: 4 cycles (ISSUE, WAIT>=1, RESP, IDLE).
REQ-026 Requesters SHALL hold i_req and operands until they see o_gnt; i_req still high in the IDLE cycle after RESP is a new request.
REQ-027 Kill: i_kill[owner]=1 at any edge while in ISSUE or WAIT SHALL set the kill flag. The operation still runs to i_m_done, but produces no o_done and no o_res update. i_kill is ignored in IDLE and RESP, and for non-owners.
REQ-028 A kill flag set on the same edge as i_m_done in WAIT SHALL take effect: no RESP.
REQ-029 Outside RESP, o_done=0 and o_res SHALL hold its last value; outside ISSUE, o_gnt=0 and o_m_start=0.
REQ-030 i_m_done high in IDLE, ISSUE or RESP SHALL be ignored.

Reset
REQ-031 i_rst=0 SHALL immediately force state IDLE, o_gnt=0, o_done=0, o_m_start=0, o_busy=0, o_res=0, captured operands 0, kill flag 0, last=NREQ-1 (requester 0 wins first).
REQ-032 Reset mid-operation SHALL abandon the operation with no o_done; a stale i_m_done after release is ignored per REQ-030.

Verification
REQ-033 Single request: req0 with rs1=7, rs2=6, f3=MUL; unit done 3 cycles after start with res=42 -> o_gnt[0] in cycle 1, o_done[0] with o_res=42 four cycles later, o_busy low afterward.
REQ-034 Simultaneous: req0 and req1 both held from reset release -> grant order 0, 1, 0, 1 over four operations; no double grant; spacing >=4 cycles.
REQ-035 Kill: req1 DIVU 100/7 granted, i_kill[1] pulsed in WAIT; unit returns 14 -> no o_done[1], o_res unchanged, FSM back to IDLE, and the next request is granted normally.
REQ-036 Kill coincident with i_m_done -> no o_done; i_kill[0] while owner=1 -> o_done[1] still fires.
REQ-037 Async reset asserted mid-WAIT -> outputs 0 within the same cycle; i_m_done=1 after release produces no o_done; a fresh req0 completes correctly.
REQ-038 Spurious i_m_done=1 held in IDLE with no request -> no state change, all pulses remain 0.
